// File: rtl/loproc_mul_accumulator_pkg.sv
// Shared constants for the LoPROC multiply-accumulate back end.
// The op encodings match the ones the issue stage puts on cmd_op.
package loproc_mul_accumulator_pkg;

    localparam int MAC_DATA_WIDTH = 32;
    localparam int MAC_Q_DEPTH    = 4;

    localparam logic [1:0] MAC_OP_MUL  = 2'b00;
    localparam logic [1:0] MAC_OP_MAC  = 2'b01;
    localparam logic [1:0] MAC_OP_MSU  = 2'b10;
    localparam logic [1:0] MAC_OP_RSVD = 2'b11;

endpackage

// File: rtl/loproc_op_fifo.sv
// Small synchronous circular FIFO with occupancy count; DEPTH must be a power of 2 (>= 2).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module loproc_op_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/loproc_mul_accumulator.sv
// HI/LO accumulator fed by loproc_multiplier products; the op for each product is
// queued at issue time and popped in order when the product arrives.
module loproc_mul_accumulator
    import loproc_mul_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = MAC_DATA_WIDTH,
    parameter int Q_DEPTH    = MAC_Q_DEPTH
) (
    input  logic                         acc_clk,
    input  logic                         acc_rst_n,
    input  logic                         cmd_valid,
    input  logic [1:0]                   cmd_op,
    output logic                         cmd_full,
    input  logic                         mul_valid,
    input  logic [DATA_WIDTH-1:0]        mul_out_l,
    input  logic [DATA_WIDTH-1:0]        mul_out_h,
    input  logic                         acc_clr,
    output logic [DATA_WIDTH-1:0]        acc_lo,
    output logic [DATA_WIDTH-1:0]        acc_hi,
    output logic                         acc_valid,
    output logic [$clog2(Q_DEPTH):0]     pending,
    output logic                         err_overflow,
    output logic                         err_underflow
);

    localparam int AW = 2 * DATA_WIDTH;

    // cmd_valid and mul_valid are single-cycle qualifiers with no back-pressure:
    // a cmd_valid while cmd_full (and no pop) is lost and flagged, and a
    // mul_valid with nothing queued is applied as MUL and flagged.
    logic              push, pop, fifo_empty;
    logic [1:0]        head_op, op_sel;
    logic [AW-1:0]     prod;
    logic [AW-1:0]     acc_q, acc_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    assign pop  = mul_valid && !fifo_empty;
    assign push = cmd_valid && (!cmd_full || mul_valid);

    loproc_op_fifo #(
        .WIDTH (2),
        .DEPTH (Q_DEPTH)
    ) u_op_fifo (
        .clk_i   (acc_clk),
        .rst_ni  (acc_rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (cmd_op),
        .rdata_o (head_op),
        .count_o (pending),
        .full_o  (cmd_full),
        .empty_o (fifo_empty)
    );

    assign prod   = {mul_out_h, mul_out_l};
    assign op_sel = fifo_empty ? MAC_OP_MUL : head_op;

    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (mul_valid) begin
            case (op_sel)
                MAC_OP_MAC: acc_d = acc_q + prod;
                MAC_OP_MSU: acc_d = acc_q - prod;
                default:    acc_d = prod;
            endcase
        end
    end

    // Clear wins over any error raised in the same cycle.
    assign valid_d = mul_valid && !acc_clr;
    assign ovf_d   = acc_clr ? 1'b0 : (ovf_q || (cmd_valid && cmd_full && !mul_valid));
    assign unf_d   = acc_clr ? 1'b0 : (unf_q || (mul_valid && fifo_empty));

    always_ff @(posedge acc_clk) begin
        if (!acc_rst_n) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign acc_lo        = acc_q[DATA_WIDTH-1:0];
    assign acc_hi        = acc_q[AW-1:DATA_WIDTH];
    assign acc_valid     = valid_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_loproc_mul_accumulator.sv
// Directed, table-driven bench for loproc_mul_accumulator (DATA_WIDTH=32, Q_DEPTH=4).
module tb_loproc_mul_accumulator;

    logic        acc_clk;
    logic        acc_rst_n;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_full;
    logic        mul_valid;
    logic [31:0] mul_out_l;
    logic [31:0] mul_out_h;
    logic        acc_clr;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic        acc_valid;
    logic [2:0]  pending;
    logic        err_overflow;
    logic        err_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] P = 64'h0000_0000_04BE_E0FE;

    typedef struct {
        logic        rst_n;
        logic        cv;
        logic [1:0]  op;
        logic        mv;
        logic [63:0] prod;
        logic        clr;
        logic [63:0] e_acc;
        logic        e_av;
        logic [2:0]  e_pend;
        logic        e_full;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    vec_t vec_q[$];

    loproc_mul_accumulator #(
        .DATA_WIDTH (32),
        .Q_DEPTH    (4)
    ) dut (
        .acc_clk       (acc_clk),
        .acc_rst_n     (acc_rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_full      (cmd_full),
        .mul_valid     (mul_valid),
        .mul_out_l     (mul_out_l),
        .mul_out_h     (mul_out_h),
        .acc_clr       (acc_clr),
        .acc_lo        (acc_lo),
        .acc_hi        (acc_hi),
        .acc_valid     (acc_valid),
        .pending       (pending),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    initial acc_clk = 1'b0;
    always #5 acc_clk = ~acc_clk;

    task automatic add(input logic rst_n, input logic cv, input logic [1:0] op,
                       input logic mv, input logic [63:0] prod, input logic clr,
                       input logic [63:0] e_acc, input logic e_av, input logic [2:0] e_pend,
                       input logic e_full, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.rst_n = rst_n; v.cv = cv; v.op = op; v.mv = mv; v.prod = prod; v.clr = clr;
        v.e_acc = e_acc; v.e_av = e_av; v.e_pend = e_pend;
        v.e_full = e_full; v.e_ovf = e_ovf; v.e_unf = e_unf;
        vec_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle past it.
    task automatic cycle(input logic rst_n, input logic cv, input logic [1:0] op,
                         input logic mv, input logic [63:0] prod, input logic clr);
        acc_rst_n = rst_n;
        cmd_valid = cv;
        cmd_op    = op;
        mul_valid = mv;
        mul_out_h = prod[63:32];
        mul_out_l = prod[31:0];
        acc_clr   = clr;
        @(posedge acc_clk);
        #1;
        acc_rst_n = 1'b1; cmd_valid = 1'b0; mul_valid = 1'b0; acc_clr = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [63:0] e_acc, input logic e_av,
                             input logic [2:0] e_pend, input logic e_full,
                             input logic e_ovf, input logic e_unf);
        check({tag, ".acc"},       {acc_hi, acc_lo}, e_acc);
        check({tag, ".acc_valid"}, 64'(acc_valid),   64'(e_av));
        check({tag, ".pending"},   64'(pending),     64'(e_pend));
        check({tag, ".cmd_full"},  64'(cmd_full),    64'(e_full));
        check({tag, ".err_ovf"},   64'(err_overflow),  64'(e_ovf));
        check({tag, ".err_unf"},   64'(err_underflow), 64'(e_unf));
    endtask

    initial begin
        acc_rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; mul_valid = 1'b0;
        mul_out_h = '0; mul_out_l = '0; acc_clr = 1'b0;

        //   rst cv op    mv prod                    clr  acc                     av pend full ovf unf
        // Reset held with traffic present
        add(0, 1, 2'b01, 1, P,                       0,   64'h0,                  0, 0, 0, 0, 0);
        add(0, 1, 2'b01, 1, P,                       0,   64'h0,                  0, 0, 0, 0, 0);
        add(1, 0, 2'b00, 0, 64'h0,                   0,   64'h0,                  0, 0, 0, 0, 0);
        // MUL then MAC
        add(1, 1, 2'b00, 0, 64'h0,                   0,   64'h0,                  0, 1, 0, 0, 0);
        add(1, 1, 2'b01, 0, 64'h0,                   0,   64'h0,                  0, 2, 0, 0, 0);
        add(1, 0, 2'b00, 1, P,                       0,   P,                      1, 1, 0, 0, 0);
        add(1, 0, 2'b00, 1, P,                       0,   64'h097D_C1FC,          1, 0, 0, 0, 0);
        add(1, 0, 2'b00, 0, 64'h0,                   0,   64'h097D_C1FC,          0, 0, 0, 0, 0);
        // MSU wrap below zero
        add(1, 1, 2'b10, 0, 64'h0,                   0,   64'h097D_C1FC,          0, 1, 0, 0, 0);
        add(1, 1, 2'b10, 0, 64'h0,                   0,   64'h097D_C1FC,          0, 2, 0, 0, 0);
        add(1, 1, 2'b10, 0, 64'h0,                   0,   64'h097D_C1FC,          0, 3, 0, 0, 0);
        add(1, 0, 2'b00, 1, P,                       0,   P,                      1, 2, 0, 0, 0);
        add(1, 0, 2'b00, 1, P,                       0,   64'h0,                  1, 1, 0, 0, 0);
        add(1, 0, 2'b00, 1, P,                       0,   64'hFFFF_FFFF_FB41_1F02, 1, 0, 0, 0, 0);
        // Queue fill, overflow drop, push+pop while full
        add(1, 1, 2'b00, 0, 64'h0,                   0,   64'hFFFF_FFFF_FB41_1F02, 0, 1, 0, 0, 0);
        add(1, 1, 2'b01, 0, 64'h0,                   0,   64'hFFFF_FFFF_FB41_1F02, 0, 2, 0, 0, 0);
        add(1, 1, 2'b01, 0, 64'h0,                   0,   64'hFFFF_FFFF_FB41_1F02, 0, 3, 0, 0, 0);
        add(1, 1, 2'b01, 0, 64'h0,                   0,   64'hFFFF_FFFF_FB41_1F02, 0, 4, 1, 0, 0);
        add(1, 1, 2'b10, 0, 64'h0,                   0,   64'hFFFF_FFFF_FB41_1F02, 0, 4, 1, 1, 0);
        add(1, 1, 2'b01, 1, 64'h10,                  0,   64'h10,                 1, 4, 1, 1, 0);
        // Drain: the dropped MSU must not appear; carry from lo into hi
        add(1, 0, 2'b00, 1, 64'h5,                   0,   64'h15,                 1, 3, 0, 1, 0);
        add(1, 0, 2'b00, 1, 64'h1_0000_0000,         0,   64'h1_0000_0015,        1, 2, 0, 1, 0);
        add(1, 0, 2'b00, 1, 64'hFFFF_FFFF,           0,   64'h2_0000_0014,        1, 1, 0, 1, 0);
        add(1, 0, 2'b00, 1, 64'h1,                   0,   64'h2_0000_0015,        1, 0, 0, 1, 0);
        // Underflow, then clear racing a queued MAC product
        add(1, 0, 2'b00, 1, 64'h478,                 0,   64'h478,                1, 0, 0, 1, 1);
        add(1, 1, 2'b01, 0, 64'h0,                   0,   64'h478,                0, 1, 0, 1, 1);
        add(1, 0, 2'b00, 1, 64'h999,                 1,   64'h0,                  0, 0, 0, 0, 0);
        add(1, 1, 2'b01, 0, 64'h0,                   0,   64'h0,                  0, 1, 0, 0, 0);
        add(1, 0, 2'b00, 1, 64'h1234,                0,   64'h1234,               1, 0, 0, 0, 0);
        // Underflow with a same-cycle push: product is MUL, the MSU queues
        add(1, 1, 2'b10, 1, 64'h7,                   0,   64'h7,                  1, 1, 0, 0, 1);
        add(1, 0, 2'b00, 1, 64'h2,                   0,   64'h5,                  1, 0, 0, 0, 1);
        add(1, 0, 2'b00, 0, 64'h0,                   1,   64'h0,                  0, 0, 0, 0, 0);

        @(posedge acc_clk);
        #1;
        for (int i = 0; i < vec_q.size(); i++) begin
            cycle(vec_q[i].rst_n, vec_q[i].cv, vec_q[i].op, vec_q[i].mv, vec_q[i].prod, vec_q[i].clr);
            check_all($sformatf("vec%0d", i), vec_q[i].e_acc, vec_q[i].e_av, vec_q[i].e_pend,
                      vec_q[i].e_full, vec_q[i].e_ovf, vec_q[i].e_unf);
        end

        // Reset in the middle of operation with ops still queued
        cycle(1, 1, 2'b00, 0, 64'h0, 0);
        cycle(1, 1, 2'b01, 0, 64'h0, 0);
        cycle(1, 1, 2'b01, 0, 64'h0, 0);
        cycle(1, 0, 2'b00, 1, 64'h1234, 0);
        check_all("midrst.pre", 64'h1234, 1, 2, 0, 0, 0);
        cycle(0, 0, 2'b00, 0, 64'h0, 0);
        check_all("midrst.rst", 64'h0, 0, 0, 0, 0, 0);
        cycle(1, 0, 2'b00, 1, 64'h55, 0);
        check_all("midrst.unf", 64'h55, 1, 0, 0, 0, 1);
        cycle(1, 0, 2'b00, 0, 64'h0, 0);
        check_all("midrst.hold", 64'h55, 0, 0, 0, 0, 1);

        // Back-to-back MACs at full rate, each seeing the previous result
        for (int i = 0; i < 4; i++) cycle(1, 1, 2'b01, 0, 64'h0, 0);
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 0, 2'b00, 1, 64'(i * 64'h1_0000_0001), 0);
            check($sformatf("b2b%0d.acc", i), {acc_hi, acc_lo},
                  64'h55 + 64'((i * (i + 1) / 2) * 64'h1_0000_0001));
            check($sformatf("b2b%0d.acc_valid", i), 64'(acc_valid), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
